// File: rtl/mem_stage_ctrl.sv
// Data-memory stage controller: turns core MemRd/MemWr into a req/ack bus transaction,
// posts stores through a one-entry write buffer and forwards loads that hit it.
module mem_stage_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              stall,
    output logic              align_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RD_DONE} state_t;

    state_t            state_reg;
    logic              wb_valid_reg;
    logic [ADDR_W-1:0] wb_adr_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              st_held_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_adr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic access, ld, st, st_new, st_wait, fwd, drain_done, capture;

    assign access     = MemRd | MemWr;
    assign align_err  = access & ((Adr[1:0] != 2'b00) | (MemRd & MemWr));
    assign ld         = MemRd & ~align_err;
    assign st         = MemWr & ~align_err;
    assign fwd        = ld & wb_valid_reg & (wb_adr_reg == Adr);
    assign drain_done = (state_reg == WR_BUSY) & mem_ack;

    // A store taken while stalled is replayed by the held core for one cycle;
    // st_held_reg retires that replay without capturing it a second time.
    assign st_new  = st & ~st_held_reg;
    assign st_wait = st_new & wb_valid_reg;
    assign capture = st_new & (~wb_valid_reg | drain_done);

    assign stall   = (ld & ~fwd & (state_reg != RD_DONE)) | st_wait;
    assign DataOut = fwd ? wb_data_reg
                   : (ld && state_reg == RD_DONE) ? rdata_reg
                   : '0;

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_adr   = mem_adr_reg;
    assign mem_wdata = mem_wdata_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wb_valid_reg  <= 1'b0;
            wb_adr_reg    <= '0;
            wb_data_reg   <= '0;
            rdata_reg     <= '0;
            st_held_reg   <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_adr_reg   <= '0;
            mem_wdata_reg <= '0;
        end else begin
            st_held_reg <= capture & st_wait;

            if (capture) begin
                wb_adr_reg   <= Adr;
                wb_data_reg  <= DataIn;
                wb_valid_reg <= 1'b1;
            end else if (drain_done) begin
                wb_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    // Draining the buffer always beats a new read, keeping order.
                    if (wb_valid_reg || capture) begin
                        state_reg     <= WR_BUSY;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b1;
                        mem_adr_reg   <= wb_valid_reg ? wb_adr_reg : Adr;
                        mem_wdata_reg <= wb_valid_reg ? wb_data_reg : DataIn;
                    end else if (ld) begin
                        state_reg   <= RD_BUSY;
                        mem_req_reg <= 1'b1;
                        mem_we_reg  <= 1'b0;
                        mem_adr_reg <= Adr;
                    end
                end
                WR_BUSY: begin
                    if (mem_ack) begin
                        if (capture) begin
                            mem_adr_reg   <= Adr;
                            mem_wdata_reg <= DataIn;
                        end else begin
                            mem_req_reg <= 1'b0;
                            state_reg   <= IDLE;
                        end
                    end
                end
                RD_BUSY: begin
                    if (mem_ack) begin
                        rdata_reg   <= mem_rdata;
                        mem_req_reg <= 1'b0;
                        state_reg   <= RD_DONE;
                    end
                end
                RD_DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
